masked_pipe_adder: RTL and testbench

First-order Boolean-masked, bit-serial-pipelined adder/subtractor, generalised from the fixed 4-bit multi-clock masked ripple-carry adder to a single-clock, WIDTH-parametrised block with a valid handshake, an add/subtract mode and explicit per-cycle fresh randomness. Each operand arrives as two shares (x = x0 ^ x1). The sum leaves as two shares and is never unmasked inside the block. It sits in the masked datapath between share generation and downstream masked logic.

---
 rtl/masked_pipe_adder_pkg.sv | 22 ++
 rtl/masked_pipe_adder_if.sv | 15 +
 rtl/masked_pipe_adder_dom_and.sv | 33 +++
 rtl/masked_pipe_adder.sv | 160 ++++++++++++++++
 tb/tb_masked_pipe_adder.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/masked_pipe_adder_pkg.sv
// Shared definitions for the masked adder datapath: share-pair type,
// parameter legality and the mapping of fresh-randomness bits to gadgets.
package masked_pkg;

  // One logical bit carried as two Boolean shares: bit = s[0] ^ s[1].
  typedef logic [1:0] share_t;

  function automatic bit width_ok(input int w);
    return (w >= 2) && (w <= 32);
  endfunction

  // Stage-0 generate gadget for bit k.
  function automatic int g_rnd_idx(input int k);
    return k;
  endfunction

  // Carry gadget of stage k (1..w); sits above the w generate bits.
  function automatic int c_rnd_idx(input int w, input int k);
    return w + k - 1;
  endfunction

endpackage

// File: rtl/masked_pipe_adder_if.sv
// Operand/result bundle of the masked adder; the block itself is the slave.
interface masked_pipe_adder_if #(parameter int WIDTH = 4);
  logic               in_valid;
  logic               sub;
  logic [WIDTH-1:0]   a0, a1, b0, b1;
  logic [2*WIDTH-1:0] rnd;
  logic               out_valid;
  logic [WIDTH:0]     s0, s1;
  logic               busy;

  modport master (output in_valid, sub, a0, a1, b0, b1, rnd,
                  input  out_valid, s0, s1, busy);
  modport slave  (input  in_valid, sub, a0, a1, b0, b1, rnd,
                  output out_valid, s0, s1, busy);
endinterface

// File: rtl/masked_pipe_adder_dom_and.sv
// First-order DOM-indep AND gadget. The four partial products are registered
// separately so domains only meet after a register; z is the per-domain
// compression that the consuming stage folds into its own logic.
module masked_dom_and import masked_pkg::*; (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  share_t x,
  input  share_t y,
  input  logic   r,
  output share_t z
);

  logic t00, t11, t01, t10;

  // Capture inner-domain and refreshed cross-domain products; hold on bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      t00 <= 1'b0;
      t11 <= 1'b0;
      t01 <= 1'b0;
      t10 <= 1'b0;
    end else if (en) begin
      t00 <= x[0] & y[0];
      t11 <= x[1] & y[1];
      t01 <= (x[0] & y[1]) ^ r;
      t10 <= (x[1] & y[0]) ^ r;
    end
  end

  assign z = {t11 ^ t10, t00 ^ t01};

endmodule

// File: rtl/masked_pipe_adder.sv
// Bit-serial pipelined masked adder/subtractor. Stage 0 captures propagate
// shares and all generate gadgets; stage k resolves sum bit k-1 and carry k
// with one DOM gadget; a final register exposes the shares. Every result
// stays split into two shares from input to output.
module masked_pipe_adder import masked_pkg::*; #(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             rst,
  masked_pipe_adder_if.slave bus
);

  // 0: capture, 1..WIDTH: carry stages, WIDTH+1: output register
  localparam int STAGES = WIDTH + 1;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("masked_pipe_adder: WIDTH must be in 2..32");
  end

  logic [STAGES:0] vld_pipe;

  // Valid bits march one stage per cycle; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.busy      = |vld_pipe;

  // ---- stage 0 ------------------------------------------------------------
  // Subtract inverts only share 0 of b, which inverts b itself.
  logic [1:0][WIDTH-1:0] bp;
  assign bp[0] = bus.sub ? ~bus.b0 : bus.b0;
  assign bp[1] = bus.b1;

  logic [1:0][WIDTH-1:0] p0_q;
  logic [1:0][WIDTH-1:0] g0_z;
  share_t                c0_q;

  // Propagate shares are linear, so each domain is formed on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q <= '0;
      c0_q <= '0;
    end else if (bus.in_valid) begin
      p0_q[0] <= bus.a0 ^ bp[0];
      p0_q[1] <= bus.a1 ^ bp[1];
      c0_q    <= {1'b0, bus.sub};
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_gen
    share_t z;
    masked_dom_and u_and (
      .clk (clk),
      .rst (rst),
      .en  (bus.in_valid),
      .x   ({bus.a1[k], bus.a0[k]}),
      .y   ({bp[1][k], bp[0][k]}),
      .r   (bus.rnd[g_rnd_idx(k)]),
      .z   (z)
    );
    assign g0_z[0][k] = z[0];
    assign g0_z[1][k] = z[1];
  end

  // ---- carry stages 1..WIDTH ----------------------------------------------
  // Stage k consumes bit 0 of the forwarded p/g vectors and passes the rest
  // on shifted down, so every stage reads the same bit position.
  for (genvar k = 1; k <= WIDTH; k++) begin : g_stg
    logic [1:0][WIDTH-k:0] p_src, g_src;
    logic [1:0][k-1:0]     s_nxt, s_q;
    share_t                p_in, g_in, c_in, s_bit, c_z, cg_q;
    logic                  en;

    assign en = vld_pipe[k-1];

    if (k == 1) begin : g_head
      assign p_src = p0_q;
      assign g_src = g0_z;
      assign c_in  = c0_q;
    end else begin : g_body
      assign p_src = g_stg[k-1].g_fwd.p_q;
      assign g_src = g_stg[k-1].g_fwd.g_q;
      assign c_in  = g_stg[k-1].cg_q ^ g_stg[k-1].c_z;
    end

    assign p_in  = {p_src[1][0], p_src[0][0]};
    assign g_in  = {g_src[1][0], g_src[0][0]};
    assign s_bit = p_in ^ c_in;

    if (k == 1) begin : g_s_head
      assign s_nxt = s_bit;
    end else begin : g_s_body
      assign s_nxt[0] = {s_bit[0], g_stg[k-1].s_q[0]};
      assign s_nxt[1] = {s_bit[1], g_stg[k-1].s_q[1]};
    end

    // p & c gadget; its compressed output joins g in the next stage.
    masked_dom_and u_and (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .x   (p_in),
      .y   (c_in),
      .r   (bus.rnd[c_rnd_idx(WIDTH, k)]),
      .z   (c_z)
    );

    // Sum bits accumulate, g_(k-1) waits alongside its gadget terms.
    always_ff @(posedge clk) begin
      if (rst) begin
        s_q  <= '0;
        cg_q <= '0;
      end else if (en) begin
        s_q  <= s_nxt;
        cg_q <= g_in;
      end
    end

    if (k < WIDTH) begin : g_fwd
      logic [1:0][WIDTH-k-1:0] p_q, g_q;

      // Forward the not-yet-consumed propagate/generate bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          p_q <= '0;
          g_q <= '0;
        end else if (en) begin
          p_q[0] <= p_src[0][WIDTH-k:1];
          p_q[1] <= p_src[1][WIDTH-k:1];
          g_q[0] <= g_src[0][WIDTH-k:1];
          g_q[1] <= g_src[1][WIDTH-k:1];
        end
      end
    end
  end

  // ---- output register ----------------------------------------------------
  share_t          c_out;
  logic [WIDTH:0]  s0_q, s1_q;

  assign c_out = g_stg[WIDTH].cg_q ^ g_stg[WIDTH].c_z;

  // Results load only on a valid slot; shares hold through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
    end else if (vld_pipe[WIDTH]) begin
      s0_q <= {c_out[0], g_stg[WIDTH].s_q[0]};
      s1_q <= {c_out[1], g_stg[WIDTH].s_q[1]};
    end
  end

  assign bus.s0 = s0_q;
  assign bus.s1 = s1_q;

endmodule

// File: tb/tb_masked_pipe_adder.sv
// Directed bench for masked_pipe_adder (WIDTH=4): latency, ordering, busy,
// reset flush and share randomisation against hand-computed results.
module tb_masked_pipe_adder;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  masked_pipe_adder_if #(.WIDTH(W)) bus ();
  masked_pipe_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         due;
    logic [W:0] exp;
  } exp_t;

  exp_t       q[$];
  bit         mon_en  = 1'b0;
  bit         mask_on = 1'b0;
  int         ncyc    = 0;
  logic [W:0] cur_exp = '0;
  logic [W:0] s0_or   = '0;
  logic [W:0] s0_and  = '1;

  // Negedge monitor: expected result due W+2 negedges after it is presented.
  initial forever begin
    exp_t e;
    @(negedge clk);
    ncyc++;
    if (mon_en) begin
      chk("busy", {31'd0, bus.busy}, {31'd0, q.size() != 0});
      if (bus.out_valid === 1'b1) begin
        if (q.size() == 0) chk("stale_out_valid", {31'd0, bus.out_valid}, 32'd0);
        else begin
          e = q.pop_front();
          chk("latency", ncyc, e.due);
          chk("sum", {27'd0, bus.s0 ^ bus.s1}, {27'd0, e.exp});
          if (mask_on) begin
            s0_or  = s0_or | bus.s0;
            s0_and = s0_and & bus.s0;
          end
        end
      end else if (q.size() != 0 && q[0].due <= ncyc) begin
        chk("missing_out_valid", {31'd0, bus.out_valid}, 32'd1);
        void'(q.pop_front());
      end
      if (rst) q.delete();
      else if (bus.in_valid) begin
        e.due = ncyc + W + 2;
        e.exp = cur_exp;
        q.push_back(e);
      end
    end
  end

  task automatic put_sh(input bit v, input bit sb, input logic [W-1:0] a0, a1, b0, b1,
                        input logic [W:0] ex);
    bus.in_valid = v;
    bus.sub      = sb;
    bus.a0       = a0;
    bus.a1       = a1;
    bus.b0       = b0;
    bus.b1       = b1;
    bus.rnd      = (2*W)'($urandom);
    cur_exp      = ex;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit sb, input logic [W-1:0] a, b, input logic [W:0] ex);
    logic [W-1:0] ra, rb;
    ra = W'($urandom);
    rb = W'($urandom);
    put_sh(1'b1, sb, ra, ra ^ a, rb, rb ^ b, ex);
  endtask

  task automatic idle(input int n);
    repeat (n) put_sh(1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.sub      = 1'b0;
    bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
    bus.rnd = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_s0", {27'd0, bus.s0}, 32'd0);
    chk("rst_s1", {27'd0, bus.s1}, 32'd0);

    // first operation on the first edge with rst low: 1 + 6
    rst = 1'b0;
    mon_en = 1'b1;
    put_sh(1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 5'b00111);
    idle(7);

    put(1'b0, 4'd15, 4'd1, 5'b10000);   // overflow into carry-out
    idle(7);
    put(1'b1, 4'd5, 4'd7, 5'b01110);    // borrow: MSB 0
    idle(7);
    put(1'b1, 4'd9, 4'd3, 5'b10110);    // a > b
    put(1'b1, 4'd6, 4'd6, 5'b10000);    // a == b
    idle(7);

    // back-to-back stream, busy must stay high throughout
    put(1'b0, 4'd3,  4'd4,  5'b00111);
    put(1'b0, 4'd15, 4'd15, 5'b11110);
    put(1'b0, 4'd0,  4'd0,  5'b00000);
    put(1'b0, 4'd9,  4'd6,  5'b01111);
    idle(7);

    // reset two edges after two acceptances; the op offered with rst is dropped
    put(1'b0, 4'd3, 4'd4, 5'b00111);
    put(1'b0, 4'd2, 4'd2, 5'b00100);
    rst = 1'b1;
    put(1'b0, 4'd1, 4'd1, 5'b00010);
    rst = 1'b0;
    chk("midrst_s0", {27'd0, bus.s0}, 32'd0);
    chk("midrst_s1", {27'd0, bus.s1}, 32'd0);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    put(1'b0, 4'd1, 4'd1, 5'b00010);
    idle(8);

    // same plaintext, fresh splits: sum constant, share 0 toggles every bit
    mask_on = 1'b1;
    repeat (100) put(1'b0, 4'd5, 4'd9, 5'b01110);
    idle(7);
    mask_on = 1'b0;
    chk("mask_s0_or", {27'd0, s0_or}, 32'h1f);
    chk("mask_s0_and", {27'd0, s0_and}, 32'h0);

    idle(3);
    chk("drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
